// File: rtl/menu_pkg.sv
// Shared definitions for the push-button menu sequencer: legal parameter
// ranges, default page indices and the page-index width helper.
package menu_pkg;

   // Legal parameter ranges, checked at elaboration by the blocks using them.
   localparam int MIN_STATES   = 2;
   localparam int MAX_STATES   = 16;
   localparam int MIN_DEBOUNCE = 2;
   localparam int MIN_BLINK    = 1;

   // Default page indices of the board menu.
   localparam int OP_SELECT = 0;
   localparam int IN_SELECT = 1;
   localparam int RES_SHOW  = 2;

   // Direction requested by the button pulses in one cycle.
   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_NEXT = 2'd1,
      STEP_BACK = 2'd2
   } step_e;

   // Width of the page index: clog2 with a floor of one bit.
   function automatic int state_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Conditions one raw board button: two-flop synchroniser, polarity
// normalisation (1 = pressed), stability debounce and a one-cycle press pulse.
module button_debouncer
   import menu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam int   CW           = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic RELEASED_RAW = logic'(ACTIVE_LOW);

   if (DEBOUNCE_CYCLES < MIN_DEBOUNCE) begin : g_bad_debounce
      $error("button_debouncer: DEBOUNCE_CYCLES must be >= %0d", MIN_DEBOUNCE);
   end

   logic [1:0]    sync_q;
   logic          pressed;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          level_dly_q;

   // Bring the asynchronous button into the clock domain.
   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= {2{RELEASED_RAW}};
      else         sync_q <= {sync_q[0], btn_i};
   end

   assign pressed = sync_q[1] ^ RELEASED_RAW;

   // Count consecutive cycles of disagreement; accept the new level once stable.
   // NOTE: every combinational output gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (pressed != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = pressed;
         else                                   cnt_d   = cnt_q + 1'b1;
      end
   end

   // Debounce counter, accepted level and its delayed copy for edge detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
      end
   end

   // Rising edge of the accepted level only; releases produce nothing.
   assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/menu_sequencer.sv
// Menu page sequencer: steps through NUM_STATES pages with wrap-around on
// debounced next/back presses, muxes the current page's 7-segment pattern and
// blinks an LED for BLINK_CYCLES after every page change.
module menu_sequencer
   import menu_pkg::*;
#(
   parameter int  NUM_STATES      = 3,
   parameter int  SEG_W           = 7,
   parameter int  DEBOUNCE_CYCLES = 20,
   parameter int  BLINK_CYCLES    = 50000,
   parameter bit  BTN_ACTIVE_LOW  = 1'b1,
   localparam int SW              = state_width(NUM_STATES)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push_button,
   input  logic                        back_button,
   input  logic [NUM_STATES*SEG_W-1:0] seg_in,
   output logic [SW-1:0]               state,
   output logic [SEG_W-1:0]            salida,
   output logic                        led,
   output logic                        changed
);

   localparam int          BW        = $clog2(BLINK_CYCLES + 1);
   localparam logic [SW-1:0] LAST_PAGE = SW'(NUM_STATES - 1);
   localparam logic [SW-1:0] HOME_PAGE = SW'(OP_SELECT);

   if (NUM_STATES < MIN_STATES || NUM_STATES > MAX_STATES) begin : g_bad_states
      $error("menu_sequencer: NUM_STATES must be in %0d..%0d", MIN_STATES, MAX_STATES);
   end
   if (BLINK_CYCLES < MIN_BLINK) begin : g_bad_blink
      $error("menu_sequencer: BLINK_CYCLES must be >= %0d", MIN_BLINK);
   end

   logic          next_press, back_press;
   step_e         step;
   logic [SW-1:0] state_q, state_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          led_q, led_d;
   logic          changed_q, changed_d;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
   ) u_next_btn (
      .clk_i   (clk),
      .rst_ni  (reset),
      .btn_i   (push_button),
      .press_o (next_press)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
   ) u_back_btn (
      .clk_i   (clk),
      .rst_ni  (reset),
      .btn_i   (back_button),
      .press_o (back_press)
   );

   // Decide the step; simultaneous opposite presses cancel out.
   always_comb begin
      step = STEP_NONE;
      if (next_press && !back_press)      step = STEP_NEXT;
      else if (back_press && !next_press) step = STEP_BACK;
   end

   // Next page with wrap-around, change pulse and LED blink window.
   always_comb begin
      state_d   = state_q;
      blink_d   = blink_q;
      led_d     = led_q;
      changed_d = (step != STEP_NONE);
      case (step)
         STEP_NEXT: state_d = (state_q == LAST_PAGE) ? '0 : state_q + 1'b1;
         STEP_BACK: state_d = (state_q == '0) ? LAST_PAGE : state_q - 1'b1;
         default:   state_d = state_q;
      endcase
      if (changed_d) begin
         led_d   = 1'b1;
         blink_d = BW'(BLINK_CYCLES - 1);
      end else if (led_q) begin
         if (blink_q == '0) led_d   = 1'b0;
         else               blink_d = blink_q - 1'b1;
      end
   end

   // Page register, blink timer and registered change pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= HOME_PAGE;
         blink_q   <= '0;
         led_q     <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         blink_q   <= blink_d;
         led_q     <= led_d;
         changed_q <= changed_d;
      end
   end

   // Pattern of the current page; page 0 is the fallback.
   always_comb begin
      salida = seg_in[0 +: SEG_W];
      for (int k = 1; k < NUM_STATES; k++) begin
         if (state_q == SW'(k)) salida = seg_in[k*SEG_W +: SEG_W];
      end
   end

   assign state   = state_q;
   assign led     = led_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_menu_sequencer.sv
// Self-checking bench for menu_sequencer: directed scenarios plus random
// button activity, compared every cycle with an event-level reference model.
module tb_menu_sequencer;

   localparam int N     = 3;
   localparam int SEG_W = 7;
   localparam int DEB   = 4;
   localparam int BLINK = 8;
   localparam int SW    = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               push_button;
   logic               back_button;
   logic [N*SEG_W-1:0] seg_in;
   logic [SW-1:0]      state;
   logic [SEG_W-1:0]   salida;
   logic               led;
   logic               changed;

   menu_sequencer #(
      .NUM_STATES      (N),
      .SEG_W           (SEG_W),
      .DEBOUNCE_CYCLES (DEB),
      .BLINK_CYCLES    (BLINK),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .push_button (push_button),
      .back_button (back_button),
      .seg_in      (seg_in),
      .state       (state),
      .salida      (salida),
      .led         (led),
      .changed     (changed)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int led_hi   = 0;
   int chg_n    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: pages as plain integers, buttons as sample histories,
   // LED as "fewer than BLINK edges since the last page change".
   int edge_cnt = 0;
   int m_state;
   int m_last;
   bit hist_p[$];
   bit hist_b[$];
   bit lvl_p, lvl_b, pend_p, pend_b;

   // A button's accepted level flips when the D synchronised samples seen so
   // far (raw samples two edges old, released before reset) all disagree.
   function automatic bit win_flip(input bit h[$], input bit lvl);
      for (int i = 0; i < DEB; i++) begin
         int idx = h.size() - 2 - i;
         bit v   = (idx >= 0) ? h[idx] : 1'b0;
         if (v == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_reset();
      m_state = 0;
      m_last  = -1000;
      hist_p.delete();
      hist_b.delete();
      lvl_p  = 0; lvl_b  = 0;
      pend_p = 0; pend_b = 0;
   endfunction

   function automatic void model_edge();
      edge_cnt++;
      if (pend_p && !pend_b) begin
         m_state = (m_state + 1) % N;
         m_last  = edge_cnt;
      end else if (pend_b && !pend_p) begin
         m_state = (m_state + N - 1) % N;
         m_last  = edge_cnt;
      end
      pend_p = 0;
      pend_b = 0;
      if (win_flip(hist_p, lvl_p)) begin lvl_p = ~lvl_p; pend_p = lvl_p; end
      if (win_flip(hist_b, lvl_b)) begin lvl_b = ~lvl_b; pend_b = lvl_b; end
      hist_p.push_back(~push_button);
      hist_b.push_back(~back_button);
      if (hist_p.size() > DEB + 2) void'(hist_p.pop_front());
      if (hist_b.size() > DEB + 2) void'(hist_b.pop_front());
   endfunction

   function automatic logic [SEG_W-1:0] exp_salida();
      return seg_in[m_state*SEG_W +: SEG_W];
   endfunction

   // One clock: model follows the edge, DUT is compared at the falling edge.
   task automatic step();
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      check("state", state, m_state);
      check("salida", salida, exp_salida());
      check("led", led, ((edge_cnt - m_last) < BLINK) ? 1 : 0);
      check("changed", changed, (m_last == edge_cnt) ? 1 : 0);
      if (led) led_hi++;
      if (changed) chg_n++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic async_reset(input int cycles);
      reset = 1'b0;
      #1;
      model_reset();
      check("rst_state", state, 0);
      check("rst_led", led, 0);
      check("rst_changed", changed, 0);
      steps(cycles);
      reset = 1'b1;
   endtask

   task automatic press_next();
      push_button = 1'b0; steps(10);
      push_button = 1'b1; steps(12);
   endtask

   task automatic press_back();
      back_button = 1'b0; steps(10);
      back_button = 1'b1; steps(12);
   endtask

   int               wrap_exp[3] = '{2, 0, 1};
   logic [SEG_W-1:0] page2;

   initial begin
      reset       = 1'b1;
      push_button = 1'b1;
      back_button = 1'b1;
      seg_in      = (N*SEG_W)'($urandom());
      #2;
      async_reset(3);

      // Reset then idle.
      led_hi = 0;
      steps(50);
      check("idle_led_cycles", led_hi, 0);
      check("idle_state", state, 0);

      // Clean next press: 7-edge latency, one step while held, 8-cycle blink.
      led_hi = 0;
      push_button = 1'b0;
      steps(6);
      check("lat_before", state, 0);
      steps(1);
      check("lat_after", state, 1);
      check("lat_changed", changed, 1);
      steps(13);
      check("hold_one_step", state, 1);
      check("blink_len", led_hi, BLINK);
      push_button = 1'b1;
      steps(12);

      // Bounce shorter than the debounce window is ignored.
      led_hi = 0;
      for (int i = 0; i < 20; i++) begin
         push_button = ((i >> 1) & 1) != 0;
         step();
      end
      push_button = 1'b1;
      steps(10);
      check("bounce_state", state, 1);
      check("bounce_led_cycles", led_hi, 0);

      // Three next presses wrap 1 -> 2 -> 0 -> 1.
      for (int k = 0; k < 3; k++) begin
         press_next();
         check("wrap_next", state, wrap_exp[k]);
      end

      // Back to page 0, then back again wraps to the last page.
      press_back();
      check("back_to_0", state, 0);
      led_hi = 0;
      press_back();
      page2 = seg_in[20:14];
      check("back_wrap", state, 2);
      check("back_salida", salida, page2);
      check("back_blink_len", led_hi, BLINK);

      // Simultaneous presses cancel.
      led_hi = 0; chg_n = 0;
      push_button = 1'b0; back_button = 1'b0;
      steps(10);
      push_button = 1'b1; back_button = 1'b1;
      steps(12);
      check("both_state", state, 2);
      check("both_led_cycles", led_hi, 0);
      check("both_changed", chg_n, 0);

      // Second change 3 cycles into a blink restarts the window: 11 cycles.
      led_hi = 0;
      push_button = 1'b0;
      steps(3);
      back_button = 1'b0;
      steps(20);
      push_button = 1'b1; back_button = 1'b1;
      steps(12);
      check("overlap_state", state, 2);
      check("overlap_led_cycles", led_hi, BLINK + 3);

      // Reset two cycles into a blink; the held button needs a fresh latency.
      push_button = 1'b0;
      steps(7);
      check("pre_rst_state", state, 0);
      steps(2);
      async_reset(2);
      steps(6);
      check("blink_rst_relatch_pre", state, 0);
      steps(1);
      check("blink_rst_relatch", state, 1);
      push_button = 1'b1;
      steps(12);

      // Reset in the middle of debouncing.
      push_button = 1'b0;
      steps(4);
      async_reset(2);
      steps(6);
      check("dbnc_rst_pre", state, 0);
      steps(1);
      check("dbnc_rst_post", state, 1);
      push_button = 1'b1;
      steps(12);

      // Random button activity, pattern updates and occasional resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(5) == 0) push_button = ~push_button;
         if ($urandom_range(7) == 0) back_button = ~back_button;
         if ($urandom_range(19) == 0) seg_in = (N*SEG_W)'($urandom());
         if ($urandom_range(199) == 0) async_reset(int'($urandom_range(1, 2)));
         else                          step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/menu_sequencer.md
Name: menu_sequencer

Overview:
- Parametrised successor to the board's push-button menu FSM. It walks NUM_STATES menu pages forward and backward, driven by two debounced buttons.
- Each press changes the page. The block selects that page's 7-segment pattern from a packed input bus and pulses an LED for BLINK_CYCLES on every page change.
- Sits between the board buttons and the per-page display-encoder modules (operation select, input select, result show, ...).

Parameters:
- NUM_STATES, 3, number of menu pages (legal range 2..16).
- SEG_W, 7, width of one 7-segment pattern.
- DEBOUNCE_CYCLES, 20, consecutive stable cycles required before a button level is accepted (legal range 2 or more).
- BLINK_CYCLES, 50000, LED on-time in clock cycles after a page change (legal range 1 or more).
- BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- push_button  input  1  raw "next page" button, asynchronous to clk
- back_button  input  1  raw "previous page" button, asynchronous to clk
- seg_in  input  NUM_STATES*SEG_W  packed page patterns; page k occupies bits [k*SEG_W +: SEG_W]
- state  output  SW = max(1,$clog2(NUM_STATES))  current page index
- salida  output  SEG_W  pattern of the current page
- led  output  1  page-change indicator
- changed  output  1  one-cycle pulse in the cycle after state updates

Behaviour:
- Reset (reset=0, asynchronous):
  - state=0, led=0, changed=0, blink counter=0.
  - Synchronisers and debounced levels reset to "released".
  - salida follows seg_in page 0 combinationally.
- Input conditioning, per button:
  - Two-flop synchroniser; polarity normalised so 1 = pressed.
  - Debounce counter increments each cycle the synchronised value differs from the debounced level, and clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the values still differ, the debounced level takes the synchronised value and the counter clears.
  - A press pulse is the registered rising edge of the debounced level: one cycle per press. Releases generate nothing.
- Latency: a clean press to the state change takes exactly 2 (sync) + DEBOUNCE_CYCLES + 1 (edge register) clock edges. Any bounce shorter than DEBOUNCE_CYCLES is ignored.
- Page FSM, state register with wrap-around:
  - next only: state = (state==NUM_STATES-1) ? 0 : state+1.
  - back only: state = (state==0) ? NUM_STATES-1 : state-1.
  - next and back press pulses in the same cycle: no change, no blink, changed stays 0.
- Holding a button gives exactly one step; auto-repeat is not supported.
- salida = seg_in slice selected by state (combinational mux, no added latency). state never exceeds NUM_STATES-1.
- LED:
  - On any state change, led=1 and the blink counter loads BLINK_CYCLES-1 in the same edge as the state update.
  - The counter decrements each cycle; led drops to 0 the cycle after the counter reaches 0.
  - A new change during a blink restarts the full BLINK_CYCLES window.
  - led is high for exactly BLINK_CYCLES cycles per isolated change.
- changed: registered, high for one cycle after each state update.
- Reset mid-blink or mid-debounce: all of the above returns immediately to the reset values. No press is remembered across reset.
- Arithmetic: blink counter width is $clog2(BLINK_CYCLES+1); debounce counter width is $clog2(DEBOUNCE_CYCLES+1). No overflow is possible by construction.

Decomposition:
- Package menu_pkg holds:
  - function for state width, clog2 with a minimum of 1;
  - localparams for the legal parameter ranges;
  - default page indices: OP_SELECT=0, IN_SELECT=1, RES_SHOW=2.
- One natural sub-module, button_debouncer, instantiated twice. It contains the synchroniser, polarity inversion, debounce counter and rising-edge pulse, and takes parameters DEBOUNCE_CYCLES and ACTIVE_LOW.
- Elaboration-time checks reject out-of-range parameters.

Test Plan:
All scenarios use NUM_STATES=3, DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, BTN_ACTIVE_LOW=1.
- Reset then idle: reset=0 for 3 cycles, release, buttons=1 → state=0, led=0, changed=0, salida=seg_in[6:0] for 50 cycles.
- Clean next press: push_button=0 held 20 cycles → state 0→1 exactly 7 edges after the low is sampled; changed high 1 cycle; led high exactly 8 cycles; salida=seg_in[13:7]; holding gives no further step.
- Bounce rejection: push_button toggles 0/1 every 2 cycles for 20 cycles, then settles at 1 → state unchanged, led=0. Then 3 next presses wrap the state 1→2→0→1.
- Back with wrap: from state=0, press back_button → state=2, salida=seg_in[20:14], led blinks 8 cycles.
- Simultaneous and overlap cases:
  - Both buttons pressed in the same cycle → state unchanged, no blink, no changed pulse.
  - A next press whose change lands 3 cycles into a blink → led stays high 8 further cycles (total 11).
- Reset mid-operation: assert reset 2 cycles into a blink, and separately mid-debounce (counter=2) → led=0 and state=0 asynchronously; after release, the held button needs a full new 7-edge latency.
